// File: rtl/playseq_pkg.sv
// Shared definitions for the button conditioning block: FSM state encodings,
// the default debounce length and a small popcount helper.
package playseq_pkg;

    localparam int DEBOUNCE_CICLOS_PADRAO = 20;

    typedef enum logic [1:0] {
        ESPERA   = 2'b00,
        ATIVO    = 2'b01,
        INVALIDO = 2'b10
    } estado_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button bit: two-flop synchronizer followed by a stable-level debouncer
// that only flips after DEBOUNCE_CICLOS consecutive differing samples.
module debounce_bit
    import playseq_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic estavel
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          estavel_q, estavel_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            estavel_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            estavel_q <= estavel_d;
            cnt_q     <= cnt_d;
        end
    end

    // Any sample equal to the stable level restarts the count, so glitches vanish.
    always_comb begin
        sync1_d   = raw;
        sync2_d   = sync1_q;
        estavel_d = estavel_q;
        cnt_d     = '0;
        if (sync2_q != estavel_q) begin
            if (cnt_q == CNT_MAX) begin
                estavel_d = ~estavel_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign estavel = estavel_q;

endmodule

// File: rtl/playseq_condiciona_botoes.sv
// Conditions four raw push buttons into debounced levels and classifies them
// with a Moore FSM, emitting a one-cycle pulse per valid single-button press.
module playseq_condiciona_botoes
    import playseq_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] botoes_raw,
    output logic [3:0] botoes,
    output logic       tem_jogada,
    output logic [3:0] jogada,
    output logic       multipla,
    output logic [1:0] db_estado
);

    logic [3:0] estavel;
    logic [2:0] n_press;
    estado_t    estado_q, estado_d;
    logic       tem_jogada_q, tem_jogada_d;
    logic [3:0] jogada_q, jogada_d;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
        ) u_debounce (
            .clock   (clock),
            .reset_n (reset_n),
            .raw     (botoes_raw[i]),
            .estavel (estavel[i])
        );
    end

    assign n_press = popcount4(estavel);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q     <= ESPERA;
            tem_jogada_q <= 1'b0;
            jogada_q     <= 4'b0000;
        end else begin
            estado_q     <= estado_d;
            tem_jogada_q <= tem_jogada_d;
            jogada_q     <= jogada_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ESPERA: begin
                if (n_press == 3'd1) begin
                    estado_d = ATIVO;
                end else if (n_press >= 3'd2) begin
                    estado_d = INVALIDO;
                end
            end
            ATIVO: begin
                if (n_press >= 3'd2) begin
                    estado_d = INVALIDO;
                end else if (n_press == 3'd0) begin
                    estado_d = ESPERA;
                end
            end
            INVALIDO: begin
                // Leaving only on full release keeps a partial release from counting as a press.
                if (n_press == 3'd0) begin
                    estado_d = ESPERA;
                end
            end
            default: estado_d = ESPERA;
        endcase
        tem_jogada_d = (estado_q == ESPERA) && (estado_d == ATIVO);
        jogada_d     = tem_jogada_d ? estavel : jogada_q;
    end

    assign botoes     = estavel;
    assign tem_jogada = tem_jogada_q;
    assign jogada     = jogada_q;
    assign multipla   = (estado_q == INVALIDO);
    assign db_estado  = estado_q;

endmodule
